txd_frame_ctrl: RTL and testbench

//  Frame scheduler that sequences the BPSK transmit datapath on clk_sig.

---
 rtl/txd_frame_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_txd_frame_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txd_frame_ctrl.sv
// rtl/txd_frame_ctrl.sv - BPSK transmit frame scheduler with payload FIFO
// Frame: preamble, sync word, length byte, payload, silent guard; outputs registered.
module txd_frame_ctrl #(
    parameter int          BIT_DIV      = 4,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] SYNC_WORD    = 16'hD391,
    parameter int          GUARD_LEN    = 8,
    parameter int          FIFO_DEPTH   = 16,
    localparam int         CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_sig,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          abort,
    output logic          tx_bit,
    output logic          tx_en,
    output logic          bit_stb,
    output logic          busy,
    output logic          done,
    output logic          fifo_full,
    output logic [CW-1:0] fifo_count,
    output logic          wr_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DW-1:0] DIV_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_LEN, S_PAY, S_GUARD} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [15:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sh_q, sh_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          bit_end, pop, wr_acc;
    logic          tx_bit_q, tx_bit_d, tx_en_q, tx_en_d, bit_stb_q, bit_stb_d;
    logic          busy_q, busy_d, done_q, done_d, full_q, full_d, drop_q, drop_d;

    always_ff @(posedge clk_sig or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            sh_q       <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            tx_bit_q   <= 1'b0;
            tx_en_q    <= 1'b0;
            bit_stb_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            sh_q       <= sh_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            tx_bit_q   <= tx_bit_d;
            tx_en_q    <= tx_en_d;
            bit_stb_q  <= bit_stb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            full_q     <= full_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk_sig) begin
        if (wr_acc) mem[wptr_q] <= wr_data;
    end

    // Next-state: every bit ends on the last divider cycle; the next byte is
    // popped on the edge that enters its first bit so its MSB is valid at once.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        sh_d       = sh_q;
        pop        = 1'b0;
        done_d     = 1'b0;
        bit_end    = (div_q == DW'(BIT_DIV - 1));
        if (abort) begin
            state_d    = S_IDLE;
            div_d      = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            if (start && count_q != '0) begin
                state_d    = S_PRE;
                len_d      = 8'(count_q);
                div_d      = '0;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
            end
        end else begin
            div_d = bit_end ? '0 : div_q + DIV_ONE;
            if (bit_end) begin
                bit_cnt_d = bit_cnt_q + 16'd1;
                case (state_q)
                    S_PRE: if (bit_cnt_q == 16'(PREAMBLE_LEN - 1)) begin
                        state_d   = S_SYNC;
                        bit_cnt_d = '0;
                    end
                    S_SYNC: if (bit_cnt_q == 16'd15) begin
                        state_d   = S_LEN;
                        bit_cnt_d = '0;
                    end
                    S_LEN: if (bit_cnt_q == 16'd7) begin
                        state_d    = S_PAY;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        pop        = 1'b1;
                        sh_d       = mem[rptr_q];
                    end
                    S_PAY: begin
                        if (bit_cnt_q == 16'd7) begin
                            bit_cnt_d = '0;
                            if (byte_cnt_q == len_q - 8'd1) begin
                                if (GUARD_LEN == 0) begin
                                    state_d = S_IDLE;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = S_GUARD;
                                end
                            end else begin
                                byte_cnt_d = byte_cnt_q + 8'd1;
                                pop        = 1'b1;
                                sh_d       = mem[rptr_q];
                            end
                        end else begin
                            sh_d = {sh_q[6:0], 1'b0};
                        end
                    end
                    S_GUARD: if (bit_cnt_q == 16'(GUARD_LEN - 1)) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // FIFO: a write during abort is discarded silently; a write while full
    // is dropped even if this cycle pops.
    always_comb begin
        wr_acc  = wr_en && !full_q && !abort;
        drop_d  = wr_en && full_q && !abort;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (abort) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PTR_ONE;
            if (pop)    rptr_d = rptr_q + PTR_ONE;
            case ({wr_acc, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == CW'(FIFO_DEPTH));
    end

    always_comb begin
        tx_bit_d  = 1'b0;
        tx_en_d   = (state_d == S_PRE) || (state_d == S_SYNC) ||
                    (state_d == S_LEN) || (state_d == S_PAY);
        busy_d    = (state_d != S_IDLE);
        bit_stb_d = tx_en_d && (div_d == '0);
        case (state_d)
            S_PRE:   tx_bit_d = ~bit_cnt_d[0];
            S_SYNC:  tx_bit_d = SYNC_WORD[~bit_cnt_d[3:0]];
            S_LEN:   tx_bit_d = len_d[~bit_cnt_d[2:0]];
            S_PAY:   tx_bit_d = sh_d[7];
            default: tx_bit_d = 1'b0;
        endcase
    end

    assign tx_bit     = tx_bit_q;
    assign tx_en      = tx_en_q;
    assign bit_stb    = bit_stb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign wr_drop    = drop_q;

endmodule

// File: tb/tb_txd_frame_ctrl.sv
// tb/tb_txd_frame_ctrl.sv - directed self-checking bench for txd_frame_ctrl
module tb_txd_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic       wr_en = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic       tx_bit0, tx_en0, bit_stb0, busy0, done0, full0, drop0;
    logic       tx_bit1, tx_en1, bit_stb1, busy1, done1, full1, drop1;
    logic [4:0] cnt0, cnt1;

    logic       sel = 1'b0;
    logic       o_tx_bit, o_tx_en, o_bit_stb, o_busy, o_done, o_full, o_drop;
    logic [4:0] o_cnt;

    int checks = 0, errors = 0;
    int div_cur = 4;

    logic       cap_q [$];
    logic       exp_q [$];
    logic [7:0] pay_q [$];
    logic [7:0] inj_q [$];
    int en_cyc, stb_cnt, first_en, last_en, done_cyc, err_misc, inj_at = -1;
    logic busy_done, last_drop;
    logic [15:0] sync_c = 16'hD391;

    always #5 clk = ~clk;

    txd_frame_ctrl dut0 (
        .clk_sig(clk), .rst(rst0), .wr_en(wr_en), .wr_data(wr_data), .start(start),
        .abort(abort), .tx_bit(tx_bit0), .tx_en(tx_en0), .bit_stb(bit_stb0), .busy(busy0),
        .done(done0), .fifo_full(full0), .fifo_count(cnt0), .wr_drop(drop0)
    );

    txd_frame_ctrl #(.BIT_DIV(1)) dut1 (
        .clk_sig(clk), .rst(rst1), .wr_en(wr_en), .wr_data(wr_data), .start(start),
        .abort(abort), .tx_bit(tx_bit1), .tx_en(tx_en1), .bit_stb(bit_stb1), .busy(busy1),
        .done(done1), .fifo_full(full1), .fifo_count(cnt1), .wr_drop(drop1)
    );

    assign o_tx_bit  = sel ? tx_bit1  : tx_bit0;
    assign o_tx_en   = sel ? tx_en1   : tx_en0;
    assign o_bit_stb = sel ? bit_stb1 : bit_stb0;
    assign o_busy    = sel ? busy1    : busy0;
    assign o_done    = sel ? done1    : done0;
    assign o_full    = sel ? full1    : full0;
    assign o_drop    = sel ? drop1    : drop0;
    assign o_cnt     = sel ? cnt1     : cnt0;

    task automatic build_exp(input int len);
        logic [7:0] lb;
        logic [7:0] pb;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(~i[0]);
        for (int i = 15; i >= 0; i--) exp_q.push_back(sync_c[i]);
        lb = 8'(len);
        for (int i = 7; i >= 0; i--) exp_q.push_back(lb[i]);
        foreach (pay_q[k]) begin
            pb = pay_q[k];
            for (int i = 7; i >= 0; i--) exp_q.push_back(pb[i]);
        end
    endtask

    function automatic int stream_diff();
        int d = 0;
        if (cap_q.size() != exp_q.size()) return 1000 + cap_q.size();
        foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
        last_drop = o_drop;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample once per cycle at the falling edge; cycle 1 is the cycle after start.
    task automatic capture(input int budget);
        cap_q.delete();
        en_cyc = 0; stb_cnt = 0; first_en = -1; last_en = -1; done_cyc = -1;
        err_misc = 0; busy_done = 1'b1;
        for (int c = 1; c <= budget && done_cyc < 0; c++) begin
            if (o_tx_en) begin
                en_cyc++;
                if (first_en < 0) first_en = c;
                last_en = c;
                if (o_bit_stb !== (((c - first_en) % div_cur) == 0)) err_misc++;
            end else if (o_bit_stb || o_tx_bit) begin
                err_misc++;
            end
            if (o_bit_stb) begin
                stb_cnt++;
                cap_q.push_back(o_tx_bit);
            end
            if (o_done) begin
                done_cyc = c;
                busy_done = o_busy;
            end
            if (inj_at >= 0 && c >= inj_at && c < inj_at + 3) begin
                wr_en = 1'b1;
                wr_data = inj_q[c - inj_at];
            end else begin
                wr_en = 1'b0;
            end
            if (done_cyc < 0) @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({tx_bit0, tx_en0, bit_stb0, busy0, done0, full0, drop0, cnt0} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0",
                     {tx_bit0, tx_en0, bit_stb0, busy0, done0, full0, drop0, cnt0});
        end
    endtask

    task automatic test_basic_frame();
        pay_q = '{8'hA5, 8'h3C};
        write_byte(8'hA5);
        write_byte(8'h3C);
        checks++;
        if (o_cnt !== 5'd2) begin errors++; $display("FAIL basic_count got %0d expected 2", o_cnt); end
        start_frame();
        capture(400);
        build_exp(2);
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL basic_stream diff %0d expected 0", stream_diff()); end
        checks++;
        if (first_en !== 1 || last_en !== 288) begin
            errors++; $display("FAIL basic_tx_en_window got %0d..%0d expected 1..288", first_en, last_en);
        end
        checks++;
        if (en_cyc !== 288 || stb_cnt !== 72) begin
            errors++; $display("FAIL basic_cycles got en=%0d stb=%0d expected 288 72", en_cyc, stb_cnt);
        end
        checks++;
        if (err_misc !== 0) begin errors++; $display("FAIL basic_stb_timing got %0d expected 0", err_misc); end
        checks++;
        if (done_cyc !== 321 || busy_done !== 1'b0) begin
            errors++; $display("FAIL basic_done got cyc=%0d busy=%b expected 321 0", done_cyc, busy_done);
        end
        checks++;
        if (o_cnt !== 5'd0) begin errors++; $display("FAIL basic_count_end got %0d expected 0", o_cnt); end
        @(negedge clk);
    endtask

    task automatic test_empty_start();
        int seen = 0;
        start_frame();
        for (int c = 0; c < 20; c++) begin
            if (o_busy || o_tx_en || o_done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL empty_start active cycles %0d expected 0", seen); end
    endtask

    task automatic test_full_fifo();
        int bad = 0;
        logic [7:0] b;
        pay_q.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'(i) ^ 8'hF0;
            pay_q.push_back(b);
            write_byte(b);
            if (last_drop !== 1'b0) bad++;
            if (o_full !== (i == 15)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL full_fill bad %0d expected 0", bad); end
        write_byte(8'hEE);
        checks++;
        if (last_drop !== 1'b1 || o_cnt !== 5'd16) begin
            errors++; $display("FAIL full_drop got drop=%b cnt=%0d expected 1 16", last_drop, o_cnt);
        end
        @(negedge clk);
        checks++;
        if (o_drop !== 1'b0) begin errors++; $display("FAIL full_drop_pulse got %b expected 0", o_drop); end
        start_frame();
        capture(1000);
        build_exp(16);
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL full_stream diff %0d expected 0", stream_diff()); end
        checks++;
        if (en_cyc !== 736 || done_cyc !== 769) begin
            errors++; $display("FAIL full_timing got en=%0d done=%0d expected 736 769", en_cyc, done_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        pay_q = '{8'h5A};
        write_byte(8'h5A);
        start_frame();
        inj_q = '{8'h12, 8'h34, 8'h56};
        inj_at = 230;
        capture(400);
        inj_at = -1;
        build_exp(1);
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL b2b_first_stream diff %0d expected 0", stream_diff()); end
        checks++;
        if (done_cyc !== 289 || o_cnt !== 5'd3) begin
            errors++; $display("FAIL b2b_first_done got done=%0d cnt=%0d expected 289 3", done_cyc, o_cnt);
        end
        pay_q = '{8'h12, 8'h34, 8'h56};
        start_frame();
        capture(500);
        build_exp(3);
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL b2b_second_stream diff %0d expected 0", stream_diff()); end
        checks++;
        if (first_en !== 1 || o_cnt !== 5'd0) begin
            errors++; $display("FAIL b2b_second_start got first=%0d cnt=%0d expected 1 0", first_en, o_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int seen = 0;
        write_byte(8'h77);
        write_byte(8'h88);
        start_frame();
        repeat (139) @(negedge clk);
        checks++;
        if (o_tx_en !== 1'b1 || o_busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre_active got en=%b busy=%b expected 1 1", o_tx_en, o_busy);
        end
        abort = 1'b1; wr_en = 1'b1; wr_data = 8'h99; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; wr_en = 1'b0; start = 1'b0;
        checks++;
        if ({o_tx_en, o_busy, o_bit_stb, o_tx_bit, o_drop, o_cnt} !== 10'h000) begin
            errors++; $display("FAIL abort_next got %b expected 0",
                               {o_tx_en, o_busy, o_bit_stb, o_tx_bit, o_drop, o_cnt});
        end
        for (int c = 0; c < 400; c++) begin
            if (o_busy || o_done || o_tx_en) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_quiet active cycles %0d expected 0", seen); end
    endtask

    task automatic test_reset_then_fast();
        write_byte(8'h81);
        start_frame();
        repeat (239) @(negedge clk);
        checks++;
        if (o_tx_en !== 1'b1) begin errors++; $display("FAIL midpay_active got %b expected 1", o_tx_en); end
        #2 rst0 = 1'b1;
        #1;
        checks++;
        if ({tx_bit0, tx_en0, bit_stb0, busy0, done0, full0, drop0, cnt0} !== 12'h000) begin
            errors++; $display("FAIL midpay_async_reset got %b expected 0",
                               {tx_bit0, tx_en0, bit_stb0, busy0, done0, full0, drop0, cnt0});
        end
        @(negedge clk);
        rst1 = 1'b0;
        sel = 1'b1;
        div_cur = 1;
        @(negedge clk);
        pay_q = '{8'hC3, 8'h81};
        write_byte(8'hC3);
        write_byte(8'h81);
        checks++;
        if (o_cnt !== 5'd2) begin errors++; $display("FAIL fast_count got %0d expected 2", o_cnt); end
        start_frame();
        capture(200);
        build_exp(2);
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL fast_stream diff %0d expected 0", stream_diff()); end
        checks++;
        if (en_cyc !== 72 || stb_cnt !== 72 || err_misc !== 0) begin
            errors++; $display("FAIL fast_stb got en=%0d stb=%0d err=%0d expected 72 72 0", en_cyc, stb_cnt, err_misc);
        end
        checks++;
        if (done_cyc !== 81) begin errors++; $display("FAIL fast_done got %0d expected 81", done_cyc); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_empty_start();
        test_full_fifo();
        test_back_to_back();
        test_abort();
        test_reset_then_fast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
